// File: rtl/luffa_host_driver.sv
// Host-side initiator for the Luffa core's 16-bit init/load/fetch/ack bus.
// Serialises one 256-bit block as 16 loads, waits for hashing, optionally fetches the 256-bit digest.
module luffa_host_driver #(
   parameter int ACK_TIMEOUT = 15,
   parameter int BUSY_GUARD  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         first_i,
   input  logic         last_i,
   input  logic [255:0] blk_i,
   output logic         ready_o,
   output logic         done_o,
   output logic         err_o,
   output logic [255:0] digest_o,
   output logic         init_o,
   output logic         load_o,
   output logic         fetch_o,
   output logic [15:0]  idata_o,
   input  logic         ack_i,
   input  logic [15:0]  odata_i,
   input  logic         busy_i
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int GW = $clog2(BUSY_GUARD + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST  = GW'(BUSY_GUARD - 1);

   typedef enum logic [3:0] {
      IDLE, INIT, LOAD, LWAIT, GUARD, HWAIT, FETCH, FWAIT, DONE
   } state_t;

   state_t         state, state_nxt;
   logic [255:0]   blk_r;
   logic [255:0]   digest_r;
   logic           last_r;
   logic [3:0]     word_cnt;
   logic [TW-1:0]  to_cnt;
   logic [GW-1:0]  guard_cnt;
   logic           timeout;
   logic [7:0]     word_lsb;

   // Word k lives at bits [255-16k -: 16], i.e. its LSB is 16*(15-k).
   assign word_lsb = {~word_cnt, 4'b0000};
   assign ready_o  = (state == IDLE);
   assign idata_o  = (state == LOAD || state == LWAIT) ? blk_r[word_lsb +: 16] : 16'h0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      init_o    = 1'b0;
      load_o    = 1'b0;
      fetch_o   = 1'b0;
      done_o    = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE:  if (start_i) state_nxt = first_i ? INIT : LOAD;
         INIT: begin
            init_o    = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            load_o    = 1'b1;
            state_nxt = LWAIT;
         end
         LWAIT: begin
            if (ack_i) begin
               state_nxt = (word_cnt == 4'd15) ? GUARD : LOAD;
            end else if (to_cnt == TO_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         GUARD: if (guard_cnt == G_LAST) state_nxt = HWAIT;
         HWAIT: if (!busy_i) state_nxt = last_r ? FETCH : DONE;
         FETCH: begin
            fetch_o   = 1'b1;
            state_nxt = FWAIT;
         end
         FWAIT: begin
            if (ack_i) begin
               state_nxt = (word_cnt == 4'd15) ? DONE : FETCH;
            end else if (to_cnt == TO_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_r     <= '0;
         digest_r  <= '0;
         digest_o  <= '0;
         last_r    <= 1'b0;
         word_cnt  <= '0;
         to_cnt    <= '0;
         guard_cnt <= '0;
         err_o     <= 1'b0;
      end else begin
         // Registered so the error pulse lands in the first IDLE cycle.
         err_o <= timeout;
         case (state)
            IDLE: begin
               if (start_i) begin
                  blk_r    <= blk_i;
                  last_r   <= last_i;
                  word_cnt <= '0;
               end
            end
            LOAD, FETCH: to_cnt <= TW'(1);
            LWAIT: begin
               to_cnt    <= to_cnt + TW'(1);
               guard_cnt <= '0;
               if (ack_i && word_cnt != 4'd15) word_cnt <= word_cnt + 4'd1;
            end
            GUARD: guard_cnt <= guard_cnt + GW'(1);
            HWAIT: if (!busy_i) word_cnt <= '0;
            FWAIT: begin
               to_cnt <= to_cnt + TW'(1);
               if (ack_i) begin
                  digest_r[word_lsb +: 16] <= odata_i;
                  if (word_cnt != 4'd15) word_cnt <= word_cnt + 4'd1;
               end
            end
            DONE: if (last_r) digest_o <= digest_r;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_luffa_host_driver.sv
// Bench for luffa_host_driver: core model acks two cycles after each strobe,
// scoreboard queue of expected bus events checked by an independent monitor.
module tb_luffa_host_driver;

   localparam int K_INIT = 1, K_LOAD = 2, K_FETCH = 3, K_DONE = 4, K_ERR = 5;

   typedef struct {
      int           kind;
      logic [255:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0, first_i = 1'b0, last_i = 1'b0;
   logic [255:0] blk_i = '0;
   logic         ready_o, done_o, err_o, init_o, load_o, fetch_o;
   logic [255:0] digest_o;
   logic [15:0]  idata_o;
   logic         ack_i = 1'b0;
   logic [15:0]  odata_i = 16'h0000;
   logic         busy_i = 1'b0;

   int           n_checks = 0, n_fail = 0, cyc = 0;
   exp_t         expq[$];
   exp_t         e;
   int           kind;
   logic [255:0] exp_dig = '0;
   bit           dig_pend = 1'b0;
   logic [255:0] dig_pend_val = '0;
   int           load_cyc[$];
   int           fetch_seen = 0, first_fetch_cyc = -1, err_cyc = -1;

   int           drop_load = 0, busy_len = 20;
   logic [15:0]  dig_base = 16'h0000;
   int           load_cnt = 0, load_acked = 0, fetch_acked = 0, busy_left = 0, busy_fall_cyc = -1;
   bit           ack_pend = 1'b0, ack_is_fetch = 1'b0;
   int           ack_at = 0;
   logic         busy_prev;

   luffa_host_driver #(.ACK_TIMEOUT(15), .BUSY_GUARD(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_i(first_i), .last_i(last_i),
      .blk_i(blk_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .digest_o(digest_o),
      .init_o(init_o), .load_o(load_o), .fetch_o(fetch_o), .idata_o(idata_o),
      .ack_i(ack_i), .odata_i(odata_i), .busy_i(busy_i)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_words(input logic [15:0] base);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 16; k++) d[255-16*k -: 16] = base + 16'(k);
      return d;
   endfunction

   // Core model: ack two cycles after a strobe, busy for busy_len cycles after the 16th load ack.
   initial forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
         ack_pend = 1'b0; ack_i = 1'b0; busy_i = 1'b0; busy_left = 0; odata_i = 16'hDEAD;
         continue;
      end
      busy_prev = busy_i;
      busy_i = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (busy_prev && !busy_i) busy_fall_cyc = cyc;
      ack_i = 1'b0;
      odata_i = 16'hDEAD;
      if (ack_pend && cyc == ack_at) begin
         ack_pend = 1'b0;
         ack_i = 1'b1;
         if (ack_is_fetch) begin
            odata_i = dig_base + 16'(fetch_acked);
            fetch_acked++;
         end else begin
            load_acked++;
            if (load_acked == 16) busy_left = busy_len;
         end
      end
      if (load_o) begin
         load_cnt++;
         if (load_cnt != drop_load) begin ack_pend = 1'b1; ack_at = cyc + 2; ack_is_fetch = 1'b0; end
      end
      if (fetch_o) begin ack_pend = 1'b1; ack_at = cyc + 2; ack_is_fetch = 1'b1; end
   end

   // Monitor: every bus event pops the next expected event.
   initial forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (dig_pend) begin chk("digest_o", digest_o, dig_pend_val); dig_pend = 1'b0; end
      if (init_o | load_o | fetch_o) chk("strobe_onehot", $countones({init_o, load_o, fetch_o}), 1);
      kind = 0;
      if (init_o) kind = K_INIT;
      else if (load_o) kind = K_LOAD;
      else if (fetch_o) kind = K_FETCH;
      else if (done_o) kind = K_DONE;
      else if (err_o) kind = K_ERR;
      if (kind == 0) continue;
      if (load_o) load_cyc.push_back(cyc);
      if (fetch_o) begin
         if (fetch_seen == 0) first_fetch_cyc = cyc;
         fetch_seen++;
         chk("fetch_while_busy", busy_i, 0);
      end
      if (err_o) begin err_cyc = cyc; chk("ready_at_err", ready_o, 1); end
      if (expq.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL unexpected_event: got kind %0d, expected none", kind);
         continue;
      end
      e = expq.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == K_LOAD) chk("idata_o", idata_o, e.data);
      if (kind == K_DONE) begin dig_pend = 1'b1; dig_pend_val = e.data; end
   end

   task automatic push_ev(input int k, input logic [255:0] d);
      exp_t x;
      x.kind = k; x.data = d;
      expq.push_back(x);
   endtask

   task automatic push_blk(input bit first, input bit last, input logic [255:0] blk, input logic [15:0] base);
      if (first) push_ev(K_INIT, '0);
      for (int k = 0; k < 16; k++) push_ev(K_LOAD, 256'(blk[255-16*k -: 16]));
      if (last) begin
         for (int k = 0; k < 16; k++) push_ev(K_FETCH, '0);
         exp_dig = mk_words(base);
      end
      push_ev(K_DONE, exp_dig);
      dig_base = base;
   endtask

   task automatic model_clear();
      load_cnt = 0; load_acked = 0; fetch_acked = 0; drop_load = 0;
      load_cyc.delete(); fetch_seen = 0; first_fetch_cyc = -1; err_cyc = -1; busy_fall_cyc = -1;
   endtask

   task automatic wait_ready(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_checks++; n_fail++; $display("FAIL %s: timeout waiting for ready_o", name); end
   endtask

   task automatic wait_quiet(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (expq.size() == 0 && !dig_pend && ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL %s: timeout, got %0d events outstanding, expected 0", name, expq.size());
      end
   endtask

   task automatic start_blk(input bit first, input bit last, input logic [255:0] blk);
      @(posedge clk); #1;
      start_i = 1'b1; first_i = first; last_i = last; blk_i = blk;
      @(posedge clk); #1;
      start_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
   endtask

   task automatic run_blk(input string name, input bit first, input bit last,
                          input logic [255:0] blk, input logic [15:0] base, input int budget);
      wait_ready(name);
      model_clear();
      push_blk(first, last, blk, base);
      start_blk(first, last, blk);
      wait_quiet(name, budget);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  dn;
      bit  ok;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready_o, 1);
      chk("rst_digest", digest_o, '0);
      chk("rst_idata", idata_o, '0);
      chk("rst_ctrl", {init_o, load_o, fetch_o, done_o, err_o}, '0);
      #2 rst_n = 1'b1;

      // Two-block message: the non-last block leaves digest_o alone.
      busy_len = 20;
      run_blk("blk2a", 1'b1, 1'b0, mk_words(16'h1000), 16'hB000, 1000);
      chk("digest_after_nonlast", digest_o, '0);
      run_blk("blk2b", 1'b0, 1'b1, mk_words(16'h2000), 16'hB000, 1000);
      chk("digest_after_last", digest_o, mk_words(16'hB000));

      run_blk("blk1", 1'b1, 1'b1, mk_words(16'h0001), 16'hA000, 1000);
      chk("digest_single", digest_o, mk_words(16'hA000));

      // Long busy: first fetch one cycle after busy is first seen low.
      busy_len = 100;
      run_blk("busy", 1'b1, 1'b1, mk_words(16'h3000), 16'hC000, 1500);
      chk("fetch_gap_after_busy", first_fetch_cyc - busy_fall_cyc, 1);
      busy_len = 20;

      // 5th load never acked.
      wait_ready("timeout");
      model_clear();
      drop_load = 5;
      push_ev(K_INIT, '0);
      for (int k = 0; k < 5; k++) push_ev(K_LOAD, 256'(16'h4000 + 16'(k)));
      push_ev(K_ERR, '0);
      start_blk(1'b1, 1'b1, mk_words(16'h4000));
      wait_quiet("timeout", 300);
      chk("err_latency", (load_cyc.size() >= 5) ? err_cyc - load_cyc[4] : -1, 15);
      chk("digest_after_err", digest_o, exp_dig);
      chk("ready_after_err", ready_o, 1);

      // start_i during LWAIT with another block is ignored.
      wait_ready("ignore_start");
      model_clear();
      push_blk(1'b0, 1'b0, mk_words(16'h5000), 16'hC000);
      start_blk(1'b0, 1'b0, mk_words(16'h5000));
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (load_cyc.size() >= 3) begin ok = 1'b1; break; end
      end
      chk("reach_third_load", ok, 1);
      @(posedge clk); #1;
      start_i = 1'b1; first_i = 1'b1; last_i = 1'b1; blk_i = mk_words(16'h6000);
      @(posedge clk); #1;
      start_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
      wait_quiet("ignore_start", 1000);
      chk("digest_after_ignored", digest_o, mk_words(16'hC000));

      // Reset while fetching word 7.
      wait_ready("reset_mid");
      model_clear();
      push_blk(1'b1, 1'b1, mk_words(16'h7000), 16'hD000);
      start_blk(1'b1, 1'b1, mk_words(16'h7000));
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (fetch_seen >= 8) begin ok = 1'b1; break; end
      end
      chk("reach_fetch7", ok, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ready", ready_o, 1);
      chk("arst_ctrl", {init_o, load_o, fetch_o, done_o, err_o}, '0);
      chk("arst_idata", idata_o, '0);
      chk("arst_digest", digest_o, '0);
      expq.delete();
      dig_pend = 1'b0;
      exp_dig = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      dn = 0;
      repeat (20) begin @(negedge clk); if (done_o || err_o) dn++; end
      chk("no_done_after_reset", dn, 0);
      run_blk("after_reset", 1'b1, 1'b1, mk_words(16'h8000), 16'hE000, 1000);
      chk("digest_after_reset_run", digest_o, mk_words(16'hE000));

      chk("queue_empty", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
